seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Consumer end of the display-digit interface driven by buttons_control_unit.
- Takes a sign bit and the three selected BCD digits (left/middle/right) and time-multiplexes them onto the Basys-class 4-digit common-anode seven-segment display.
- Digit 3 (leftmost) shows the sign; digits 2..0 show left/middle/right.
- Inputs are snapshotted once per frame so a scan never mixes old and new values; optional leading-zero blanking.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range >= 2.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sign  input  1  1 = value negative, show '-' on digit 3
left_digit  input  4  BCD, displayed on digit 2
middle_digit  input  4  BCD, displayed on digit 1
right_digit  input  4  BCD, displayed on digit 0
lz_blank  input  1  1 = blank leading zeros on digits 2 and 1
anode  output  4  active-low digit enables, anode[0] = rightmost
seg  output  7  active-low segments {g,f,e,d,c,b,a}
frame_start  output  1  one-cycle pulse when a new frame (digit 0) begins

Behaviour:
- Reset (asynchronous, rst_n=0): immediately cnt=0, idx=3, snapshot regs=0, anode=4'b1111, seg=7'b1111111, frame_start=0. Holds while rst_n=0.
- Refresh counter cnt: counts 0..REFRESH_DIV-1 and wraps. tick = (cnt==REFRESH_DIV-1).
- Slot index idx (2 bits): on a tick edge, idx <= idx+1, with wrap 3->0.
- Slot order: 0,1,2,3,0,...
  - The first tick after reset occurs on cycle REFRESH_DIV after release.
  - That tick selects idx 0.
- Snapshot: on a tick edge where idx==3 (transition to 0), capture sign, left_digit, middle_digit, right_digit and lz_blank.
  - Between captures, input changes have no visible effect.
- Outputs are registered and update only on tick edges, from the newly selected idx and the snapshot.
  - For idx 0, use the values captured on that same edge.
  - anode: idx0=1110, idx1=1101, idx2=1011, idx3=0111. Exactly one digit is active after the first tick.
- frame_start: 1 for exactly the one cycle following the tick edge that selected idx 0; otherwise 0.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, blank=1111111
- Digit 3: minus if snapshot sign=1, else blank.
- Leading-zero blanking (lz_blank=1):
  - Digit 2 is blank if left==0.
  - Digit 1 is blank if left==0 and middle==0.
  - Digit 0 is never blanked.
- With lz_blank=0, all three digits always display.
- BCD codes 10..15 on any digit display blank.
  - A non-BCD left digit counts as non-zero for the blanking chain.
- Reset mid-frame: outputs return immediately to their reset values. After release, the block resumes exactly as from power-up.
- No combinational path from any input to any output.

Test Plan:
- Reset/start (REFRESH_DIV=4): hold rst_n=0, then release.
  -> anode=1111, seg=1111111 for 4 cycles.
  -> at the 4th edge after release: anode=1110, frame_start=1 for exactly 1 cycle.
- Normal scan: sign=1, left=1, middle=2, right=3, lz_blank=0.
  -> every 4 cycles: anode/seg step through 1110/0110000, 1101/0100100, 1011/1111001, 0111/0111111, then repeat.
- Snapshot: during slot 1, change right 3->7.
  -> digit 0 still shows 0110000 until the next frame.
  -> the next frame shows 1111000.
- Leading zeros: lz_blank=1, sign=0, left=0, middle=0, right=0.
  -> digits 3, 2 and 1 show 1111111; digit 0 shows 1000000.
  -> then middle=5: digit 1 shows 0010010 and digit 2 stays blank.
- Invalid BCD: right=12, lz_blank=0.
  -> digit 0 slot shows 1111111; the other digits are unaffected.
- Mid-frame reset: assert rst_n=0 while anode=1011.
  -> anode=1111 and seg=1111111 before the next clk edge.
  -> after release, the first frame_start comes exactly 4 cycles later.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
// Time-multiplexes a sign and three BCD digits onto a 4-digit common-anode
// seven-segment display. Digit 3 (leftmost) shows the sign, and digits 2..0
// show left/middle/right. All inputs are snapshotted once per frame, at the
// slot-3 -> slot-0 transition, so a single scan never mixes old and new values.
// Outputs are registered and change only on refresh ticks.
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sign,
  input  logic [3:0] left_digit,
  input  logic [3:0] middle_digit,
  input  logic [3:0] right_digit,
  input  logic       lz_blank,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             snap_sign_q, snap_sign_d;
  logic [3:0]       snap_left_q, snap_left_d;
  logic [3:0]       snap_mid_q, snap_mid_d;
  logic [3:0]       snap_right_q, snap_right_d;
  logic             snap_lz_q, snap_lz_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_start_q, frame_start_d;
  logic             tick;

  // Active-low {g,f,e,d,c,b,a} pattern; codes 10..15 render as blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Next-state logic for refresh counter, slot index, snapshot and outputs.
  // Outputs are computed from the *next* slot and *next* snapshot so that
  // slot 0 shows the values captured on the same tick edge.
  always_comb begin
    tick          = (cnt_q == CNT_MAX);
    cnt_d         = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    snap_sign_d   = snap_sign_q;
    snap_left_d   = snap_left_q;
    snap_mid_d    = snap_mid_q;
    snap_right_d  = snap_right_q;
    snap_lz_d     = snap_lz_q;
    anode_d       = anode_q;
    seg_d         = seg_q;
    frame_start_d = 1'b0;

    if (tick) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        snap_sign_d   = sign;
        snap_left_d   = left_digit;
        snap_mid_d    = middle_digit;
        snap_right_d  = right_digit;
        snap_lz_d     = lz_blank;
        frame_start_d = 1'b1;
      end

      anode_d = ~(4'b0001 << idx_d);
      case (idx_d)
        2'd3: seg_d = snap_sign_d ? SEG_MINUS : SEG_BLANK;
        2'd2: seg_d = (snap_lz_d && snap_left_d == 4'd0) ? SEG_BLANK
                                                          : bcd_to_seg(snap_left_d);
        2'd1: seg_d = (snap_lz_d && snap_left_d == 4'd0 && snap_mid_d == 4'd0)
                      ? SEG_BLANK : bcd_to_seg(snap_mid_d);
        default: seg_d = bcd_to_seg(snap_right_d);
      endcase
    end
  end

  // State registers; reset parks idx at 3 so the first tick selects slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= 2'd3;
      snap_sign_q   <= 1'b0;
      snap_left_q   <= 4'd0;
      snap_mid_q    <= 4'd0;
      snap_right_q  <= 4'd0;
      snap_lz_q     <= 1'b0;
      anode_q       <= 4'b1111;
      seg_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_sign_q   <= snap_sign_d;
      snap_left_q   <= snap_left_d;
      snap_mid_q    <= snap_mid_d;
      snap_right_q  <= snap_right_d;
      snap_lz_q     <= snap_lz_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign anode       = anode_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Testbench for seven_seg_scanner with REFRESH_DIV=4. A behavioural display
// model computes the expected anode/segment pattern for each slot from the
// frame values the bench drove, and checks every cycle of every frame.
module tb_seven_seg_scanner;

  localparam int DIV = 4;

  typedef struct {
    logic       sgn;
    logic [3:0] l;
    logic [3:0] m;
    logic [3:0] r;
    logic       lz;
  } frame_t;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk;
  logic       rst_n;
  logic       sign;
  logic [3:0] left_digit;
  logic [3:0] middle_digit;
  logic [3:0] right_digit;
  logic       lz_blank;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       frame_start;

  int n_checks;
  int n_pass;
  frame_t cur;
  frame_t nxt;

  seven_seg_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sign         (sign),
    .left_digit   (left_digit),
    .middle_digit (middle_digit),
    .right_digit  (right_digit),
    .lz_blank     (lz_blank),
    .anode        (anode),
    .seg          (seg),
    .frame_start  (frame_start)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what a given digit position shows for a frame value.
  function automatic logic [6:0] model_seg(input int slot, input frame_t f);
    int  val;
    bit  blank;
    val   = 0;
    blank = 1'b0;
    if (slot == 3) return f.sgn ? MINUS : BLANK;
    if (slot == 2) begin
      val   = int'(f.l);
      blank = f.lz && (f.l == 0);
    end else if (slot == 1) begin
      val   = int'(f.m);
      blank = f.lz && (f.l == 0) && (f.m == 0);
    end else begin
      val   = int'(f.r);
    end
    if (blank || val > 9) return BLANK;
    return SEG_TAB[val];
  endfunction

  function automatic logic [3:0] model_anode(input int slot);
    logic [3:0] a;
    a = 4'b1111;
    a[slot] = 1'b0;
    return a;
  endfunction

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 3) == 0) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    f.sgn = 1'($urandom_range(0, 1));
    f.l   = rand_digit();
    f.m   = rand_digit();
    f.r   = rand_digit();
    f.lz  = 1'($urandom_range(0, 1));
    return f;
  endfunction

  function automatic frame_t mk(input logic s, input logic [3:0] l, input logic [3:0] m,
                                input logic [3:0] r, input logic lz);
    frame_t f;
    f.sgn = s; f.l = l; f.m = m; f.r = r; f.lz = lz;
    return f;
  endfunction

  // Driver
  task automatic drive(input frame_t f);
    sign         = f.sgn;
    left_digit   = f.l;
    middle_digit = f.m;
    right_digit  = f.r;
    lz_blank     = f.lz;
  endtask

  // From a release of reset (at a negedge), check the blank lead-in cycles,
  // then step to the first slot-0 negedge.
  task automatic check_lead_in(input string tag);
    for (int k = 0; k < DIV; k++) begin
      n_checks++;
      if (anode !== 4'b1111 || seg !== BLANK || frame_start !== 1'b0)
        $display("FAIL %s_lead_in cycle %0d: anode=%b seg=%b fs=%b, want 1111/1111111/0",
                 tag, k, anode, seg, frame_start);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (anode !== 4'b1110 || frame_start !== 1'b1)
      $display("FAIL %s_first_tick: anode=%b fs=%b, want 1110/1", tag, anode, frame_start);
    else n_pass++;
  endtask

  // Checks one whole frame (16 cycles) against cur, starting at the slot-0
  // negedge. Mid-frame it drives junk then nxt; the frame must ignore both
  // and the following frame must show nxt.
  task automatic check_frame(input string tag);
    for (int c = 0; c < 4 * DIV; c++) begin
      int slot;
      slot = c / DIV;
      n_checks++;
      if (anode !== model_anode(slot) || seg !== model_seg(slot, cur) ||
          frame_start !== (c == 0))
        $display("FAIL %s cycle %0d: anode=%b seg=%b fs=%b, want %b/%b/%b",
                 tag, c, anode, seg, frame_start, model_anode(slot),
                 model_seg(slot, cur), (c == 0));
      else n_pass++;
      if (c == 5) drive(rand_frame());
      if (c == 9) drive(nxt);
      @(negedge clk);
    end
    cur = nxt;
  endtask

  task automatic test_reset();
    cur = mk(1'b1, 4'd1, 4'd2, 4'd3, 1'b0);
    drive(cur);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (anode !== 4'b1111 || seg !== BLANK || frame_start !== 1'b0)
      $display("FAIL reset_hold: anode=%b seg=%b fs=%b, want 1111/1111111/0",
               anode, seg, frame_start);
    else n_pass++;
    rst_n = 1'b1;
    check_lead_in("reset");
  endtask

  task automatic test_normal_scan();
    nxt = cur;
    check_frame("normal_scan_a");
    check_frame("normal_scan_b");
  endtask

  task automatic test_snapshot();
    nxt = cur;
    nxt.r = 4'd7;
    check_frame("snapshot_old");
    nxt = cur;
    check_frame("snapshot_new");
  endtask

  task automatic test_leading_zero();
    nxt = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    check_frame("lz_setup");
    nxt = mk(1'b0, 4'd0, 4'd5, 4'd0, 1'b1);
    check_frame("lz_all_zero");
    nxt = mk(1'b0, 4'd11, 4'd0, 4'd4, 1'b1);
    check_frame("lz_middle5");
    nxt = mk(1'b1, 4'd0, 4'd0, 4'd0, 1'b0);
    check_frame("lz_nonbcd_left");
    check_frame("lz_disabled");
  endtask

  task automatic test_invalid_bcd();
    nxt = mk(1'b1, 4'd1, 4'd2, 4'd12, 1'b0);
    check_frame("bcd_setup");
    nxt = mk(1'b0, 4'd15, 4'd10, 4'd9, 1'b0);
    check_frame("bcd_right12");
    check_frame("bcd_left15");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      nxt = rand_frame();
      check_frame("random");
    end
  endtask

  task automatic test_mid_frame_reset();
    repeat (2 * DIV) @(negedge clk);
    n_checks++;
    if (anode !== 4'b1011)
      $display("FAIL mid_reset_slot2: anode=%b, want 1011", anode);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (anode !== 4'b1111 || seg !== BLANK || frame_start !== 1'b0)
      $display("FAIL mid_reset_async: anode=%b seg=%b fs=%b, want 1111/1111111/0",
               anode, seg, frame_start);
    else n_pass++;
    repeat (2) @(negedge clk);
    cur = rand_frame();
    drive(cur);
    rst_n = 1'b1;
    check_lead_in("mid_reset");
    nxt = rand_frame();
    check_frame("after_reset");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive(mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0));
    @(negedge clk);
    test_reset();
    test_normal_scan();
    test_snapshot();
    test_leading_zero();
    test_invalid_bcd();
    test_random();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
